capp_sequencer: RTL
===================

# capp_sequencer

Command sequencer for the content-addressable cell array. It accepts search, write and read commands over a valid/ready handshake and converts each mask/key pair into the array's dual-rail `match_lines` and `write_lines`. It holds the lines stable for programmable settle and write windows, then samples `tags` and `read_lines`. It returns a response with hit flag, responder count, lowest responder index and read data, and sits between the host command port and the cell array.

## Interface
- `WORDS`, 100: number of words in the array; width of `tags`.
- `WIDTH`, 32: word width; `match_lines` and `write_lines` are 2*WIDTH.
- `SETTLE`, 2: cycles match lines are held before sampling; must be ≥1.
- `WRITE_CYCLES`, 1: cycles write lines are asserted; must be ≥1.
- Derived: `CW` = $clog2(WORDS+1); `IW` = $clog2(WORDS).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: command opcode; 0=SEARCH, 1=WRITE, 2=READ, 3=illegal.
- `cmd_key` in WIDTH: search key (SEARCH) or write data (WRITE).
- `cmd_mask` in WIDTH: search mask (SEARCH) or write mask (WRITE).
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_hit` out 1: at least one responder.
- `rsp_count` out CW: number of responders.
- `rsp_first` out IW: lowest responder index; 0 when `rsp_hit`=0.
- `rsp_data` out WIDTH: sampled `read_lines`.
- `rsp_err` out 1: illegal opcode.
- `match_lines` out 2*WIDTH / `write_lines` out 2*WIDTH: array drive.
- `tags` in WORDS / `read_lines` in WIDTH: array outputs.

## Operation
- Dual-rail encoding per bit j:
  - `match_lines[2j]` = mask[j]&key[j]; `match_lines[2j+1]` = mask[j]&~key[j].
  - `write_lines[2j]` = wmask[j]&wdata[j]; `write_lines[2j+1]` = wmask[j]&~wdata[j].
- Registers `key_q`/`mask_q` hold the last SEARCH key and mask. Reset value is 0, which drives no match lines and yields no responders.
- FSM states: IDLE, DRIVE, WRITE, RESP.
  - IDLE: `cmd_ready`=1. On accept:
    - SEARCH loads `key_q`/`mask_q`, then goes to DRIVE.
    - WRITE latches the write data/mask, then goes to DRIVE.
    - READ goes to DRIVE with `key_q`/`mask_q` unchanged.
    - Illegal opcode goes to RESP with `rsp_err`=1 and all other response fields 0.
  - DRIVE: `match_lines` driven from `key_q`/`mask_q` for SETTLE cycles. On the last DRIVE edge, `tags` and `read_lines` are sampled into the response registers. SEARCH/READ then go to RESP; WRITE goes to WRITE.
  - WRITE: `match_lines` held; `write_lines` asserted for WRITE_CYCLES cycles, then go to RESP. Responder fields report the tags sampled in DRIVE.
  - RESP: `rsp_valid`=1; all fields stable until `rsp_ready`. Go to IDLE on handshake.
- `match_lines` is 0 outside DRIVE/WRITE. `write_lines` is 0 outside WRITE.
- `rsp_count`: popcount of the `tags` snapshot. `rsp_first`: priority encode, lowest index wins. `rsp_hit` = `rsp_count`≠0.
- WRITE with zero responders still runs the full write window and returns `rsp_hit`=0.
- Search mask 0 gives `rsp_hit`=0 and `rsp_count`=0.

## Timing
- Reset values while `rst` is high, and immediately on assertion:
  - State IDLE; `cmd_ready`=0 while `rst` is high.
  - `rsp_valid`=0; all `rsp_*`=0.
  - `match_lines`=0, `write_lines`=0; `key_q`/`mask_q`=0.
- First accept is possible on the first edge after `rst` falls.
- Latency from the accept edge to `rsp_valid` high:
  - SEARCH/READ: SETTLE edges.
  - WRITE: SETTLE+WRITE_CYCLES edges.
  - Illegal: 1 edge.
- Only one command is in flight. `cmd_ready`=0 from the accept edge until the response handshake completes.
- A response handshake and a new command acceptance never occur in the same cycle.
- Reset mid-operation aborts the command and clears the drive lines asynchronously. No response is issued. `key_q`/`mask_q` are cleared.
- All outputs are registered; no combinational path from `tags`/`read_lines` to outputs.

## Test plan
- Reset: hold `rst` high for 3 cycles during a WRITE -> `write_lines`=0 and `match_lines`=0 within the same cycle. After release, `cmd_ready`=1 and `rsp_valid`=0.
- SEARCH key=0x000000A5, mask=0x000000FF; bench asserts tags {3,17,42} -> during DRIVE `match_lines[3:0]`=4'b1001. `rsp_valid` is high 2 edges after accept with `rsp_hit`=1, `rsp_count`=3, `rsp_first`=3.
- WRITE data=0xFFFF0000, mask=0xFFFF0000 after that SEARCH -> `write_lines[63:32]`=0x55555555 and `write_lines[31:0]`=0, asserted exactly 1 cycle with `match_lines` unchanged. Response comes 3 edges after accept with `rsp_count`=3.
- READ with bench `read_lines`=0xDEADBEEF -> `rsp_data`=0xDEADBEEF 2 edges after accept. Array is driven with the previous SEARCH key.
- Backpressure: `rsp_ready`=0 for 5 cycles -> response fields stable, `cmd_ready`=0, `match_lines`=0. Handshake returns the FSM to IDLE.
- `cmd_op`=3 -> `rsp_err`=1 after 1 edge, `match_lines`/`write_lines` stay 0, `key_q`/`mask_q` unchanged. A SEARCH immediately after reset returns `rsp_count`=0 when the bench drives `tags`=0.

Source files
------------

// File: rtl/capp_sequencer_if.sv
// capp_sequencer_if: host-side command/response bundle for the CAM sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_key/cmd_mask : command channel (host -> sequencer)
//   rsp_valid/rsp_ready/rsp_hit/rsp_count/rsp_first/rsp_data/rsp_err : response channel
// master = host side, slave = sequencer side.
interface capp_sequencer_if #(
    parameter int WORDS = 100,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WORDS + 1);
    localparam int IW = $clog2(WORDS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_key;
    logic [WIDTH-1:0] cmd_mask;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [CW-1:0]    rsp_count;
    logic [IW-1:0]    rsp_first;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_count, rsp_first, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_count, rsp_first, rsp_data, rsp_err
    );
endinterface

// File: rtl/capp_sequencer.sv
// capp_sequencer: command sequencer for the content-addressable cell array.
// Turns SEARCH/WRITE/READ commands into dual-rail match/write line drive, holds
// them for the settle/write windows, snapshots tags/read_lines and returns
// hit, responder count, lowest responder index and read data.
//   clk, rst            : clock, asynchronous active-high reset
//   bus (slave)         : command / response handshake bundle
//   match_lines (out)   : dual-rail search drive, 2*WIDTH
//   write_lines (out)   : dual-rail write drive, 2*WIDTH
//   tags (in)           : per-word match flags from the array
//   read_lines (in)     : read data from the array
module capp_sequencer #(
    parameter int WORDS        = 100,
    parameter int WIDTH        = 32,
    parameter int SETTLE       = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    capp_sequencer_if.slave      bus,
    output logic [2*WIDTH-1:0]   match_lines,
    output logic [2*WIDTH-1:0]   write_lines,
    input  logic [WORDS-1:0]     tags,
    input  logic [WIDTH-1:0]     read_lines
);
    localparam int CW   = $clog2(WORDS + 1);
    localparam int IW   = $clog2(WORDS);
    localparam int MAXC = (SETTLE > WRITE_CYCLES) ? SETTLE : WRITE_CYCLES;
    localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] WRITE_LAST  = CNTW'(WRITE_CYCLES - 1);

    localparam logic [1:0] OP_SEARCH = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_READ   = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_WRITE, ST_RESP} state_e;

    state_e             state_q;
    logic [1:0]         op_q;
    logic [CNTW-1:0]    cnt_q;
    logic [WIDTH-1:0]   key_q, mask_q;
    logic [WIDTH-1:0]   wdata_q, wmask_q;
    logic [2*WIDTH-1:0] match_q, write_q;
    logic               rsp_valid_q, rsp_hit_q, rsp_err_q;
    logic [CW-1:0]      rsp_count_q;
    logic [IW-1:0]      rsp_first_q;
    logic [WIDTH-1:0]   rsp_data_q;

    logic [CW-1:0]      count_d;
    logic [IW-1:0]      first_d;

    // Bit j drives rail 2j when the masked bit must be 1, rail 2j+1 when it must be 0.
    function automatic logic [2*WIDTH-1:0] dual_rail(input logic [WIDTH-1:0] k,
                                                     input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++) begin
            r[2*j]   = m[j] & k[j];
            r[2*j+1] = m[j] & ~k[j];
        end
        return r;
    endfunction

    // Popcount and lowest-index priority encode of the live tags; only
    // consumed on the sampling edge, so tags never reach an output directly.
    always_comb begin
        count_d = '0;
        first_d = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (tags[i]) begin
                count_d = count_d + CW'(1);
                first_d = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            match_q     <= '0;
            write_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_count_q <= '0;
            rsp_first_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q  <= bus.cmd_op;
                        cnt_q <= '0;
                        case (bus.cmd_op)
                            OP_SEARCH: begin
                                key_q     <= bus.cmd_key;
                                mask_q    <= bus.cmd_mask;
                                match_q   <= dual_rail(bus.cmd_key, bus.cmd_mask);
                                rsp_err_q <= 1'b0;
                                state_q   <= ST_DRIVE;
                            end
                            OP_WRITE: begin
                                wdata_q   <= bus.cmd_key;
                                wmask_q   <= bus.cmd_mask;
                                match_q   <= dual_rail(key_q, mask_q);
                                rsp_err_q <= 1'b0;
                                state_q   <= ST_DRIVE;
                            end
                            OP_READ: begin
                                match_q   <= dual_rail(key_q, mask_q);
                                rsp_err_q <= 1'b0;
                                state_q   <= ST_DRIVE;
                            end
                            default: begin
                                // Illegal op: error response, no array activity.
                                rsp_err_q   <= 1'b1;
                                rsp_hit_q   <= 1'b0;
                                rsp_count_q <= '0;
                                rsp_first_q <= '0;
                                rsp_data_q  <= '0;
                                state_q     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q       <= '0;
                        rsp_count_q <= count_d;
                        rsp_hit_q   <= (count_d != '0);
                        rsp_first_q <= first_d;
                        rsp_data_q  <= read_lines;
                        if (op_q == OP_WRITE) begin
                            write_q <= dual_rail(wdata_q, wmask_q);
                            state_q <= ST_WRITE;
                        end else begin
                            match_q     <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == WRITE_LAST) begin
                        cnt_q       <= '0;
                        write_q     <= '0;
                        match_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_RESP: begin
                    // Illegal commands arrive here with rsp_valid low; the first
                    // RESP cycle raises it, giving a one-edge latency after accept.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_first = rsp_first_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign match_lines   = match_q;
    assign write_lines   = write_q;
endmodule
